changer_seq: RTL

//  Sequencer around the bit-toggle datapath: applies a queued stream of bit-index commands to one operand.
//  A start loads operand i_a and a job length; commands arrive on a valid/ready port into a small FIFO.
//  RUN pops one command per cycle and toggles bit acc[idx]. An invalid index aborts the job.

---
 rtl/changer_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/changer_seq.sv
// Command sequencer: a start loads an operand, then queued bit-index commands
// toggle accumulator bits one per cycle until the job length is reached or a bad index aborts.
module changer_seq #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [N-1:0]  i_a,
  input  logic [LW-1:0] i_len,
  input  logic [N-1:0]  i_b,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  output logic [N-1:0]  o_out,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ERR,
  output logic [LW-1:0] o_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Sign bit set, or magnitude not addressing a bit of the operand, is rejected.
  function automatic logic idx_bad(input logic [N-1:0] cmd);
    return cmd[N-1] || (32'(cmd[N-2:0]) >= 32'(N));
  endfunction

  function automatic logic [N-1:0] bit_mask(input logic [N-1:0] cmd);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (32'(cmd[N-2:0]) == 32'(i));
    end
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] occ_q, occ_d;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic [N-1:0]  head_s;

  assign full_s    = (occ_q == OCC_FULL);
  assign empty_s   = (occ_q == '0);
  assign head_s    = mem_q[rd_q];
  assign o_b_ready = !full_s && (state_q != ST_ERR) && !i_rst;
  assign push_s    = i_b_valid && o_b_ready;

  assign o_out  = acc_q;
  assign o_busy = (state_q == ST_RUN);
  assign o_done = (state_q == ST_DONE);
  assign o_ERR  = (state_q == ST_ERR);
  assign o_cnt  = cnt_q;

  // Job control: start handling, command execution and abort on a bad index.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pop_s   = 1'b0;
    flush_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          acc_d   = i_a;
          cnt_d   = '0;
          len_d   = i_len;
          state_d = (i_len == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (empty_s) begin
          state_d = ST_RUN;
        end else if (idx_bad(head_s)) begin
          // Clearing acc on abort makes o_out read zero for the whole ERR stay.
          pop_s   = 1'b1;
          flush_s = 1'b1;
          acc_d   = '0;
          state_d = ST_ERR;
        end else begin
          pop_s = 1'b1;
          acc_d = acc_q ^ bit_mask(head_s);
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == (len_q - CNT_ONE)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a flush overrides any same-cycle push.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (flush_s) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      if (push_s && !pop_s) begin
        occ_d = occ_q + OCC_ONE;
      end else if (pop_s && !push_s) begin
        occ_d = occ_q - OCC_ONE;
      end else begin
        occ_d = occ_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_s && !flush_s) begin
        mem_q[wr_q] <= i_b;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

endmodule
